irq_pend_latch: RTL and testbench

- Upstream companion of the 8-to-3 priority encoder.
- Synchronises eight asynchronous request lines and edge-detects them. Each detected event is latched into a pending register.
- The masked pending vector drives the encoder's 8-bit input.
- Takes the encoder's 3-bit result back as the acknowledge code, clears the served line, and counts events lost while a line was already pending.

---
 rtl/irq_pend_latch.sv | 108 ++++++++++
 tb/tb_irq_pend_latch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pend_latch.sv
// irq_pend_latch: synchronises and edge-detects eight request lines, latches events as pending,
// and clears them on encoder acknowledge while counting events lost to an already-pending line.
`default_nettype none

module irq_pend_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  input  logic [7:0]       mask,
  input  logic             ack,
  input  logic [2:0]       ack_code,
  input  logic             ovf_clr,
  output logic [7:0]       pend,
  output logic             irq,
  output logic [7:0]       ovf,
  output logic [CNT_W-1:0] lost_cnt,
  output logic             ack_err
);

  localparam int SUM_W = CNT_W + 4;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]       hist_q;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       ovf_q, ovf_d;
  logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
  logic             irq_q, irq_d;
  logic             ack_err_q, ack_err_d;

  logic [7:0]       event_w;
  logic [7:0]       ack_sel_w;
  logic [7:0]       clr_w;
  logic [7:0]       lost_w;
  logic [2:0]       ack_bit_w;
  logic [3:0]       lost_n_w;
  logic [CNT_W-1:0] cnt_base_w;
  logic [SUM_W-1:0] cnt_sum_w;

  // Synchroniser chain per line plus the edge-detect history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    event_w   = sync_q[SYNC_STAGES-1] & ~hist_q;
    // Encoder code c names bit 7-c.
    ack_bit_w = 3'd7 - ack_code;
    ack_sel_w = ack ? (8'b1 << ack_bit_w) : 8'b0;
    clr_w     = ack_sel_w & pend_q;
    lost_w    = event_w & pend_q & ~clr_w;
    // A fresh event beats a same-cycle clear.
    pend_d    = (pend_q & ~clr_w) | event_w;
    ovf_d     = (ovf_clr ? 8'b0 : ovf_q) | lost_w;

    lost_n_w = 4'd0;
    for (int i = 0; i < 8; i++) begin
      lost_n_w = lost_n_w + 4'(lost_w[i]);
    end

    cnt_base_w = ovf_clr ? '0 : lost_cnt_q;
    cnt_sum_w  = SUM_W'(cnt_base_w) + SUM_W'(lost_n_w);
    if (cnt_sum_w[SUM_W-1:CNT_W] != '0) begin
      lost_cnt_d = '1;
    end else begin
      lost_cnt_d = cnt_sum_w[CNT_W-1:0];
    end

    ack_err_d = ack & ~pend_q[ack_bit_w];
    irq_d     = |(pend_q & ~mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      ovf_q      <= '0;
      lost_cnt_q <= '0;
      irq_q      <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      lost_cnt_q <= lost_cnt_d;
      irq_q      <= irq_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign pend     = pend_q & ~mask;
  assign irq      = irq_q;
  assign ovf      = ovf_q;
  assign lost_cnt = lost_cnt_q;
  assign ack_err  = ack_err_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_pend_latch.sv
// tb_irq_pend_latch: directed and random stimulus against a cycle-level reference model.
`default_nettype none

module tb_irq_pend_latch;

  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    req;
  logic [7:0]    mask;
  logic          ack;
  logic [2:0]    ack_code;
  logic          ovf_clr;
  logic [7:0]    pend;
  logic          irq;
  logic [7:0]    ovf;
  logic [CW-1:0] lost_cnt;
  logic          ack_err;

  int checks = 0;
  int errors = 0;

  // Reference model: req samples taken at past edges, plus architectural state.
  logic [7:0] m_smp [0:S];
  logic [7:0] m_pend;
  logic [7:0] m_ovf;
  int         m_lost;
  logic       m_irq;
  logic       m_aerr;

  irq_pend_latch #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .ack_code (ack_code),
    .ovf_clr  (ovf_clr),
    .pend     (pend),
    .irq      (irq),
    .ovf      (ovf),
    .lost_cnt (lost_cnt),
    .ack_err  (ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= S; i++) m_smp[i] = 8'h00;
    m_pend = 8'h00;
    m_ovf  = 8'h00;
    m_lost = 0;
    m_irq  = 1'b0;
    m_aerr = 1'b0;
  endtask

  // An event is a req level seen S edges ago that was low the edge before that.
  task automatic model_step();
    logic [7:0] ev, nxt, lostbits;
    int         n;
    int         tgt;
    ev       = m_smp[S-1] & ~m_smp[S];
    nxt      = m_pend;
    lostbits = 8'h00;
    n        = 0;
    tgt      = 7 - int'(ack_code);
    for (int b = 0; b < 8; b++) begin
      logic clr;
      clr = ack && (tgt == b) && m_pend[b];
      if (ev[b]) begin
        if (m_pend[b] && !clr) begin
          lostbits[b] = 1'b1;
          n++;
        end
        nxt[b] = 1'b1;
      end else if (clr) begin
        nxt[b] = 1'b0;
      end
    end
    m_aerr = ack && !m_pend[tgt];
    m_irq  = |(m_pend & ~mask);
    m_lost = ovf_clr ? n : m_lost + n;
    if (m_lost > CMAX) m_lost = CMAX;
    m_ovf  = (ovf_clr ? 8'h00 : m_ovf) | lostbits;
    m_pend = nxt;
    for (int i = S; i > 0; i--) m_smp[i] = m_smp[i-1];
    m_smp[0] = req;
  endtask

  task automatic chk_all();
    chk("pend",     32'(pend),     32'(m_pend & ~mask));
    chk("irq",      32'(irq),      32'(m_irq));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    chk("lost_cnt", 32'(lost_cnt), 32'(m_lost));
    chk("ack_err",  32'(ack_err),  32'(m_aerr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic ack_tick(input logic [2:0] code);
    ack      = 1'b1;
    ack_code = code;
    tick();
    ack      = 1'b0;
    ack_code = $urandom_range(0, 7);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_pend",    32'(pend),     32'h0);
    chk("rst_irq",     32'(irq),      32'h0);
    chk("rst_ovf",     32'(ovf),      32'h0);
    chk("rst_lost",    32'(lost_cnt), 32'h0);
    chk("rst_ack_err", 32'(ack_err),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; mask = 8'h00; ack = 1'b0; ack_code = 3'd0; ovf_clr = 1'b0;
    apply_reset();

    // Idle after reset.
    repeat (10) tick();
    chk("idle_pend", 32'(pend), 32'h0);

    // Single line: pend at third edge, irq one edge later, cleared by code 7.
    req = 8'h01;
    tick(); tick(); tick();
    chk("e2_pend", 32'(pend), 32'h01);
    chk("e2_irq",  32'(irq),  32'h0);
    tick();
    chk("e3_irq",  32'(irq),  32'h1);
    ack_tick(3'b111);
    chk("ack0_pend", 32'(pend), 32'h00);
    chk("ack0_irq",  32'(irq),  32'h1);
    tick();
    chk("ack0_irq_off", 32'(irq), 32'h0);
    req = 8'h00;
    repeat (3) tick();

    // Two simultaneous lines.
    req = 8'h84;
    repeat (3) tick();
    chk("dual_pend", 32'(pend), 32'h84);
    ack_tick(3'b101);
    chk("dual_ack2", 32'(pend), 32'h80);
    ack_tick(3'b000);
    chk("dual_ack7", 32'(pend), 32'h00);
    req = 8'h00;
    repeat (3) tick();

    // Repeated event on a pending line is lost.
    req = 8'h08; repeat (2) tick();
    req = 8'h00; repeat (2) tick();
    req = 8'h08; repeat (2) tick();
    req = 8'h00; repeat (3) tick();
    chk("lost_pend3", 32'(pend[3]),  32'h1);
    chk("lost_ovf",   32'(ovf),      32'h08);
    chk("lost_cnt1",  32'(lost_cnt), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_ovf",   32'(ovf),      32'h00);
    chk("clr_cnt",   32'(lost_cnt), 32'd0);
    chk("clr_pend3", 32'(pend[3]),  32'h1);

    // Event on bit 5 coinciding with its acknowledge: stays pending, not lost.
    req = 8'h20; repeat (3) tick();
    req = 8'h00; repeat (2) tick();
    req = 8'h20; tick(); tick();
    ack_tick(3'b010);
    chk("race_pend5", 32'(pend[5]),  32'h1);
    chk("race_ovf5",  32'(ovf[5]),   32'h0);
    chk("race_cnt",   32'(lost_cnt), 32'd0);
    req = 8'h00;
    ack_tick(3'b100);
    chk("clr3_pend", 32'(pend), 32'h20);
    ack_tick(3'b100);
    chk("aerr_pulse", 32'(ack_err), 32'h1);
    chk("aerr_pend",  32'(pend),    32'h20);
    tick();
    chk("aerr_drop",  32'(ack_err), 32'h0);
    ack_tick(3'b010);
    tick();

    // Mask hides but still latches.
    mask = 8'hFF;
    req  = 8'h02;
    repeat (4) tick();
    chk("mask_pend", 32'(pend), 32'h00);
    chk("mask_irq",  32'(irq),  32'h0);
    mask = 8'h00;
    req  = 8'h00;
    tick();
    chk("unmask_pend", 32'(pend), 32'h02);
    repeat (2) tick();

    // Saturation: many lost events on line 1.
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    repeat (300) begin
      req = 8'h02; tick();
      req = 8'h00; tick();
    end
    repeat (3) tick();
    chk("sat_cnt", 32'(lost_cnt), 32'd255);
    chk("sat_ovf", 32'(ovf),      32'h02);

    // Reset in the middle of activity.
    req = 8'h5A;
    tick();
    apply_reset();
    repeat (4) tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      req     = 8'($urandom);
      mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ovf_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        ack_tick(3'($urandom_range(0, 7)));
      end else begin
        ack_code = 3'($urandom_range(0, 7));
        tick();
      end
      ovf_clr = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
